// File: rtl/jpeg_mem_arbiter.sv
// Round-robin arbiter sharing one 16-bit zero-latency Avalon-MM master between clients A and B.
// Optional macro ARB_STATS_EN adds per-client transfer/wait counters and a stat_clr input.
module jpeg_mem_arbiter #(
    parameter int HOLD = 4,
    parameter int AW   = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_address,
    input  logic          a_read,
    input  logic          a_write,
    input  logic [15:0]   a_writedata,
    input  logic [1:0]    a_byteenable,
    output logic [15:0]   a_readdata,
    output logic          a_waitrequest,
    input  logic [AW-1:0] b_address,
    input  logic          b_read,
    input  logic          b_write,
    input  logic [15:0]   b_writedata,
    input  logic [1:0]    b_byteenable,
    output logic [15:0]   b_readdata,
    output logic          b_waitrequest,
`ifdef ARB_STATS_EN
    input  logic          stat_clr,
    output logic [31:0]   stat_a_xfers,
    output logic [31:0]   stat_b_xfers,
    output logic [31:0]   stat_a_wait,
    output logic [31:0]   stat_b_wait,
`endif
    output logic [AW-1:0] m_address,
    output logic          m_read,
    output logic          m_write,
    output logic [15:0]   m_writedata,
    output logic [1:0]    m_byteenable,
    input  logic [15:0]   m_readdata,
    input  logic          m_waitrequest
);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW:0]   HOLD_W = (CW+1)'(HOLD);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_t;

    state_t        state_r, state_s;
    logic          last_r, last_s;       // 1'b0 = A granted last, 1'b1 = B
    logic [CW-1:0] hold_cnt_r, hold_cnt_s;
    logic [CW:0]   hold_inc_s;
    logic          req_a_s, req_b_s;

    assign req_a_s    = a_read | a_write;
    assign req_b_s    = b_read | b_write;
    assign hold_inc_s = {1'b0, hold_cnt_r} + {{CW{1'b0}}, 1'b1};
    assign a_readdata = m_readdata;
    assign b_readdata = m_readdata;

    // State, last-grantee and hold-window registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= 1'b1;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            last_r     <= last_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // Next-state arbitration: release, hold-window expiry, or stall
    always_comb begin
        state_s    = state_r;
        last_s     = last_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (req_a_s && (!req_b_s || last_r)) begin
                    state_s = GNT_A; last_s = 1'b0; hold_cnt_s = '0;
                end else if (req_b_s) begin
                    state_s = GNT_B; last_s = 1'b1; hold_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            GNT_A: begin
                if (!req_a_s) begin
                    hold_cnt_s = '0;
                    if (req_b_s) begin
                        state_s = GNT_B; last_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (!m_waitrequest) begin
                    if (hold_inc_s >= HOLD_W && req_b_s) begin
                        state_s = GNT_B; last_s = 1'b1; hold_cnt_s = '0;
                    end else if (hold_inc_s >= HOLD_W) begin
                        hold_cnt_s = HOLD_C;
                    end else begin
                        hold_cnt_s = hold_inc_s[CW-1:0];
                    end
                end else begin
                    state_s = GNT_A;
                end
            end
            GNT_B: begin
                if (!req_b_s) begin
                    hold_cnt_s = '0;
                    if (req_a_s) begin
                        state_s = GNT_A; last_s = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (!m_waitrequest) begin
                    if (hold_inc_s >= HOLD_W && req_a_s) begin
                        state_s = GNT_A; last_s = 1'b0; hold_cnt_s = '0;
                    end else if (hold_inc_s >= HOLD_W) begin
                        hold_cnt_s = HOLD_C;
                    end else begin
                        hold_cnt_s = hold_inc_s[CW-1:0];
                    end
                end else begin
                    state_s = GNT_B;
                end
            end
            default: begin
                state_s = IDLE; last_s = 1'b1; hold_cnt_s = '0;
            end
        endcase
    end

    // Master command mux and client stalls, driven straight from the grant state
    always_comb begin
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = 16'h0000;
        m_byteenable  = 2'b00;
        a_waitrequest = 1'b1;
        b_waitrequest = 1'b1;
        case (state_r)
            GNT_A: begin
                m_address     = a_address;
                m_read        = a_read;
                m_write       = a_write;
                m_writedata   = a_writedata;
                m_byteenable  = a_byteenable;
                a_waitrequest = m_waitrequest;
            end
            GNT_B: begin
                m_address     = b_address;
                m_read        = b_read;
                m_write       = b_write;
                m_writedata   = b_writedata;
                m_byteenable  = b_byteenable;
                b_waitrequest = m_waitrequest;
            end
            default: begin
                m_read  = 1'b0;
                m_write = 1'b0;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    logic acc_a_s, acc_b_s;
    assign acc_a_s = (state_r == GNT_A) && req_a_s && !m_waitrequest;
    assign acc_b_s = (state_r == GNT_B) && req_b_s && !m_waitrequest;

    // Transfer and wait counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_a_xfers <= 32'd0;
            stat_b_xfers <= 32'd0;
            stat_a_wait  <= 32'd0;
            stat_b_wait  <= 32'd0;
        end else if (stat_clr) begin
            stat_a_xfers <= 32'd0;
            stat_b_xfers <= 32'd0;
            stat_a_wait  <= 32'd0;
            stat_b_wait  <= 32'd0;
        end else begin
            stat_a_xfers <= stat_a_xfers + {31'd0, acc_a_s};
            stat_b_xfers <= stat_b_xfers + {31'd0, acc_b_s};
            stat_a_wait  <= stat_a_wait + {31'd0, req_a_s & a_waitrequest};
            stat_b_wait  <= stat_b_wait + {31'd0, req_b_s & b_waitrequest};
        end
    end
`endif

endmodule

// File: doc/jpeg_mem_arbiter.md
Name: jpeg_mem_arbiter

Overview:
Shares the single 16-bit Avalon-MM master port to HPS memory between two requesters: client A (JPEG source-pixel reader) and client B (JPEG output-stream writer). Each client sees a private Avalon-MM master-style interface with waitrequest. Transfers use zero-latency read data, valid in the accept cycle, with no readdatavalid. The block does round-robin arbitration with a bounded hold window so a streaming client can issue back-to-back transfers without starving the other.

Parameters:
HOLD, 4, max consecutive accepted transfers by the current grantee while the other client is waiting (>=1)
AW, 31, word address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
a_address  in  AW  client A word address
a_read  in  1  client A read request
a_write  in  1  client A write request
a_writedata  in  16  client A write data
a_byteenable  in  2  client A byte enables
a_readdata  out  16  read data to A
a_waitrequest  out  1  stall to A
b_address, b_read, b_write, b_writedata, b_byteenable, b_readdata, b_waitrequest: same as client A, for client B
m_address  out  AW  master address
m_read  out  1  master read
m_write  out  1  master write
m_writedata  out  16  master write data
m_byteenable  out  2  master byte enables
m_readdata  in  16  master read data
m_waitrequest  in  1  master stall

Behaviour:
- Client request: req_X = X_read | X_write. Read and write asserted together by one client is illegal; it is forwarded unchanged and the result is undefined.
- States: IDLE, GNT_A, GNT_B. Registers: last (last granted client), hold_cnt (0..HOLD).
- Reset, applied asynchronously: state=IDLE, last=B so A wins the first tie, hold_cnt=0.
- Outputs are combinational from state:
  - IDLE: m_read=m_write=0, m_address=0, m_writedata=0, m_byteenable=0, a_waitrequest=b_waitrequest=1.
  - GNT_X: all m_* command signals mirror client X. X_waitrequest=m_waitrequest. The other client's waitrequest=1.
- Read data: a_readdata=b_readdata=m_readdata always. It is meaningful only to the grantee in its accept cycle.
- Accept: state GNT_X & req_X & !m_waitrequest.
- Grant latency: one cycle. A request seen in IDLE gets its grant on the next edge; the earliest accept is that next cycle.
- IDLE transitions:
  - Both requesting: grant the client != last.
  - One requesting: grant that client.
  - None: stay IDLE.
  - On any grant: hold_cnt=0, last=grantee.
- GNT_X transitions:
  - !req_X: if req_other, go to GNT_other (last=other, hold_cnt=0); else IDLE.
  - Accept with hold_cnt+1>=HOLD and req_other: go to GNT_other, hold_cnt=0, last=other.
  - Accept otherwise: stay in GNT_X, hold_cnt=min(hold_cnt+1, HOLD). The count saturates; no switch until the other client requests.
  - Stalled (req_X & m_waitrequest): hold state. Master command stays stable; no switch mid-transfer.
- A client dropping its request while stalled is treated as a release, following the !req_X rule.
- Reset mid-transfer drops m_read/m_write immediately, asynchronously. Clients must re-issue.
- Throughput: with one requester, one transfer per cycle once granted. Switching between clients costs zero bubble cycles when the other is already requesting.

Optional Feature:
ARB_STATS_EN:
- Adds outputs stat_a_xfers[31:0], stat_b_xfers[31:0], stat_a_wait[31:0] and stat_b_wait[31:0], plus input stat_clr.
- xfers increments on each accept by that client.
- wait increments every cycle the client requests with its waitrequest=1.
- Counters wrap modulo 2^32, reset to 0 on rst, and clear synchronously on stat_clr. stat_clr wins over a same-cycle increment.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- A only, read addr 0x100, m_waitrequest=0 -> cycle 1 IDLE (a_waitrequest=1); cycle 2 m_read=1, m_address=0x100, accept; a_readdata=m_readdata that cycle.
- A and B both request from reset, m_waitrequest=0, HOLD=4, continuous -> accepts A,A,A,A,B,B,B,B,A... with no idle cycles after the first.
- B write 0xBEEF with byteenable 2'b01, m_waitrequest high for 3 cycles while A requests -> m_* stable for 4 cycles, one write accepted, then grant moves to A.
- A granted with B idle, 10 continuous accepts -> all go to A, hold_cnt saturates at 4; B requests at transfer 7 -> B is granted after A's next accept.
- rst pulsed mid-stall on a B write -> m_write=0 immediately, state IDLE; after release, A wins the tie.
- ARB_STATS_EN: 5 A accepts plus 3 B stall cycles -> stat_a_xfers=5, stat_b_wait=3; stat_clr -> all counters 0 next cycle.
